// File: rtl/serial_mod_div_pkg.sv
// Shared types and helpers for the bit-serial constant-divisor engine.
package serial_mod_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest width that can hold every remainder 0 .. divisor-1.
    function automatic int calc_rem_w(input int divisor);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(divisor)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_mod_div_step.sv
// One remainder-FSM step: folds bit b into remainder r for a constant divisor.
module mod_step
    import serial_mod_div_pkg::*;
#(
    parameter int DIVISOR = 3,
    parameter int REM_W   = calc_rem_w(DIVISOR)
) (
    input  logic [REM_W-1:0] i_r,
    input  logic             i_b,
    output logic [REM_W-1:0] o_r_next,
    output logic             o_q
);

    localparam logic [REM_W:0] DIV_T = (REM_W+1)'(DIVISOR);

    // 2r+1 <= 2*DIVISOR-1 always fits in REM_W+1 bits, so one subtract suffices.
    logic [REM_W:0] w_t;
    assign w_t = {i_r, i_b};

    // Conditional subtract producing the next remainder and quotient bit.
    always_comb begin
        o_r_next = w_t[REM_W-1:0];
        o_q      = 1'b0;
        if (w_t >= DIV_T) begin
            o_r_next = REM_W'(w_t - DIV_T);
            o_q      = 1'b1;
        end else begin
            o_r_next = w_t[REM_W-1:0];
            o_q      = 1'b0;
        end
    end

endmodule

// File: rtl/serial_mod_div.sv
// Bit-serial MSB-first divide/modulo by a constant, valid/ready on both sides.
// Optional quotient-bit stream enabled by defining SERIAL_MOD_DIV_STREAM_EN.
module serial_mod_div
    import serial_mod_div_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 3,
    parameter int REM_W   = calc_rem_w(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quo,
    output logic [REM_W-1:0] rem,
    output logic             divisible
`ifdef SERIAL_MOD_DIV_STREAM_EN
   ,output logic             q_bit,
    output logic             q_bit_valid
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_quo;
    logic [REM_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_divisible;
    logic [REM_W-1:0]   w_r_next;
    logic               w_q;
    logic               w_accept;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign quo       = r_quo;
    assign rem       = r_rem;
    assign divisible = r_divisible;

    mod_step #(
        .DIVISOR (DIVISOR),
        .REM_W   (REM_W)
    ) u_step (
        .i_r      (r_rem),
        .i_b      (r_shift[WIDTH-1]),
        .o_r_next (w_r_next),
        .o_q      (w_q)
    );

    // Control FSM and datapath registers; DONE may reload directly for back-to-back words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= {WIDTH{1'b0}};
            r_quo       <= {WIDTH{1'b0}};
            r_rem       <= {REM_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_out_valid <= 1'b0;
            r_divisible <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift     <= in_data;
                        r_rem       <= {REM_W{1'b0}};
                        r_cnt       <= CNT_W'(WIDTH - 1);
                        r_divisible <= 1'b0;
                        r_state     <= SHIFT;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                SHIFT: begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_rem   <= w_r_next;
                    r_quo   <= {r_quo[WIDTH-2:0], w_q};
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_divisible <= (w_r_next == {REM_W{1'b0}});
                    end else begin
                        r_state     <= SHIFT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_shift     <= in_data;
                            r_rem       <= {REM_W{1'b0}};
                            r_cnt       <= CNT_W'(WIDTH - 1);
                            r_divisible <= 1'b0;
                            r_state     <= SHIFT;
                        end else begin
                            r_state     <= IDLE;
                        end
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_MOD_DIV_STREAM_EN
    logic r_q_bit;
    logic r_q_bit_valid;

    assign q_bit       = r_q_bit;
    assign q_bit_valid = r_q_bit_valid;

    // Registered copy of each SHIFT cycle's quotient bit, MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_bit       <= 1'b0;
            r_q_bit_valid <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_q_bit       <= w_q;
            r_q_bit_valid <= 1'b1;
        end else begin
            r_q_bit_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_mod_div.sv
// Directed bench for serial_mod_div: DIVISOR 3 and DIVISOR 7 instances, arithmetic model.
module tb_serial_mod_div;

    logic        clk;
    logic        rst_n;
    logic [1:0]  iv, ir, ov, orr, dv;
    logic [7:0]  id [2];
    logic [7:0]  q  [2];
    logic [2:0]  rm [2];
    logic [1:0]  rem3;
    logic [2:0]  rem7;
    logic [1:0]  qb, qbv;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int div_of [2] = '{3, 7};

    bit         busy [2] = '{0, 0};
    int         due  [2];
    logic [7:0] op   [2];

    serial_mod_div #(.WIDTH(8), .DIVISOR(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .quo(q[0]), .rem(rem3), .divisible(dv[0])
`ifdef SERIAL_MOD_DIV_STREAM_EN
       ,.q_bit(qb[0]), .q_bit_valid(qbv[0])
`endif
    );

    serial_mod_div #(.WIDTH(8), .DIVISOR(7)) dut7 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .quo(q[1]), .rem(rem7), .divisible(dv[1])
`ifdef SERIAL_MOD_DIV_STREAM_EN
       ,.q_bit(qb[1]), .q_bit_valid(qbv[1])
`endif
    );

`ifndef SERIAL_MOD_DIV_STREAM_EN
    assign qb  = 2'b00;
    assign qbv = 2'b00;
`endif

    assign rm[0] = {1'b0, rem3};
    assign rm[1] = rem7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: result = floor(op/d), op mod d, valid 8 edges after accept, held until taken.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                busy[k] = 1'b0;
                chk("rst_out_valid", ov[k], 0);
                chk("rst_in_ready", ir[k], 1);
                chk("rst_quo", q[k], 0);
                chk("rst_rem", rm[k], 0);
                chk("rst_divisible", dv[k], 0);
                chk("rst_q_bit_valid", qbv[k], 0);
                chk("rst_q_bit", qb[k], 0);
            end else begin
                bit         exp_ov;
                bit         exp_ir;
                logic [7:0] qe;
                exp_ov = busy[k] && (cyc >= due[k]);
                exp_ir = !busy[k] || (exp_ov && orr[k]);
                qe     = 8'(int'(op[k]) / div_of[k]);
                chk("out_valid", ov[k], int'(exp_ov));
                chk("in_ready", ir[k], int'(exp_ir));
                if (exp_ov) begin
                    chk("quo", q[k], int'(qe));
                    chk("rem", rm[k], int'(op[k]) % div_of[k]);
                    chk("divisible", dv[k], int'((int'(op[k]) % div_of[k]) == 0));
                end
`ifdef SERIAL_MOD_DIV_STREAM_EN
                if (busy[k] && (cyc >= due[k] - 7) && (cyc <= due[k])) begin
                    chk("q_bit_valid", qbv[k], 1);
                    chk("q_bit", qb[k], int'(qe[due[k] - cyc]));
                end else begin
                    chk("q_bit_valid", qbv[k], 0);
                end
`endif
                if (exp_ov && orr[k]) busy[k] = 1'b0;
                if (iv[k] && exp_ir) begin
                    busy[k] = 1'b1;
                    op[k]   = id[k];
                    due[k]  = cyc + 9;
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d);
        bit ok;
        ok    = 1'b0;
        iv[k] = 1'b1;
        id[k] = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ir[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", int'(ok), 1);
        @(posedge clk);
        #1 iv[k] = 1'b0;
    endtask

    task automatic wait_ov(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov[k]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("out_valid_timeout", int'(ok), 1);
    endtask

    task automatic get(input int k, input int eq, input int er, input int hold);
        wait_ov(k);
        chk("lit_quo", q[k], eq);
        chk("lit_rem", rm[k], er);
        chk("lit_divisible", dv[k], int'(er == 0));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            iv[k] = h[0];
            id[k] = 8'hA5;
        end
        if (hold > 0) begin
            chk("lit_hold_quo", q[k], eq);
            chk("lit_hold_rem", rm[k], er);
        end
        iv[k]  = 1'b0;
        orr[k] = 1'b1;
        @(posedge clk);
        #1 orr[k] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        iv    = 2'b00;
        orr   = 2'b00;
        id[0] = 8'd0;
        id[1] = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(0, 8'd169);
        get(0, 56, 1, 0);

        // Back-to-back: 255 is taken in the DONE cycle of 170.
        orr[0] = 1'b1;
        send(0, 8'd170);
        iv[0] = 1'b1;
        id[0] = 8'd255;
        wait_ov(0);
        chk("lit_b2b_quo", q[0], 56);
        chk("lit_b2b_rem", rm[0], 2);
        chk("lit_b2b_in_ready", ir[0], 1);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        get(0, 85, 0, 0);
        orr[0] = 1'b0;

        send(0, 8'd0);
        get(0, 0, 0, 0);

        send(0, 8'd77);
        get(0, 25, 2, 5);

        send(0, 8'd200);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send(0, 8'd9);
        get(0, 3, 0, 0);

        send(1, 8'd100);
        get(1, 14, 2, 0);
        send(1, 8'd0);
        get(1, 0, 0, 0);
        send(1, 8'd255);
        get(1, 36, 3, 2);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/serial_mod_div.md
# serial_mod_div

Clocked, parametrised bit-serial modulo/divide engine: the successor to the 8-bit combinational divide-by-3 state machine. It accepts a WIDTH-bit unsigned word over a valid/ready handshake and walks the bits MSB-first through a DIVISOR-state remainder FSM, one bit per clock. It returns quotient, remainder and a divisible flag over a second valid/ready handshake. It sits in the digital datapath wherever a constant-divisor check or divide is needed without a full divider.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIVISOR, 3: constant divisor; must be ≥ 2. Non-powers-of-two and powers of two are both legal.
- REM_W, $clog2(DIVISOR): derived remainder width; not to be overridden.
- clk  in  1  the single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  an operand is present on in_data.
- in_ready  out  1  the block can accept an operand this cycle.
- in_data  in  WIDTH  unsigned operand.
- out_valid  out  1  a result is present.
- out_ready  in  1  the consumer takes the result this cycle.
- quo  out  WIDTH  quotient, floor(in_data / DIVISOR).
- rem  out  REM_W  remainder, in_data mod DIVISOR.
- divisible  out  1  set when rem == 0.
- q_bit, q_bit_valid  out  1 each  present only with SERIAL_MOD_DIV_STREAM_EN; see Configuration.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid && in_ready: load a shift register with in_data, clear the remainder register r to 0, load the bit counter to WIDTH-1, go to SHIFT.
- **SHIFT:** each cycle, with b = current MSB of the shift register:
  - t = 2r + b, computed at REM_W+1 bits.
  - If t ≥ DIVISOR: r ← t − DIVISOR and the quotient bit is 1. Otherwise r ← t and the quotient bit is 0.
  - Because r < DIVISOR, one conditional subtract is always sufficient.
  - The quotient bit shifts into quo from the LSB side. The shift register shifts left. The counter decrements.
  - When the counter is 0 this cycle, go to DONE.
- **DONE:**
  - out_valid = 1. quo, rem and divisible hold steady until the handshake completes.
  - On out_ready: if in_valid is also high, accept the new operand directly into SHIFT (back-to-back). Otherwise go to IDLE.
- **in_ready** = (state == IDLE) || (state == DONE && out_ready). It is low throughout SHIFT.
- in_data and in_valid are ignored while in_ready is low.
- For DIVISOR = 3, the remainder FSM is identical to the existing remainder-0/1/2 machine, generalised to DIVISOR states.

## Timing
- **Reset values:** state = IDLE, in_ready = 1, out_valid = 0, quo = 0, rem = 0, divisible = 0, q_bit = 0, q_bit_valid = 0.
- **Latency:** operand accepted on rising edge k → out_valid high from edge k+WIDTH.
- **Throughput:** one word per WIDTH+1 cycles with back-to-back handshakes. No throughput loss beyond that one DONE cycle.
- **Backpressure:** out_ready may stay low indefinitely. Outputs must not change and in_ready stays low.
- **Reset mid-operation:** an asynchronous rst_n drop in any state aborts the operation. The partial result is discarded, no out_valid is produced, and the block returns to reset values.
- **Boundary operands:**
  - in_data = 0 → quo 0, rem 0, divisible 1.
  - in_data = 2^WIDTH − 1 must be exact, with no overflow of t.

## Configuration
- **SERIAL_MOD_DIV_STREAM_EN defined:**
  - Adds ports q_bit and q_bit_valid.
  - q_bit_valid is high in each SHIFT cycle, registered one cycle later: WIDTH consecutive pulses, the last coinciding with out_valid rising.
  - q_bit carries that cycle's quotient bit, MSB first.
- **Macro undefined:** the ports and their logic do not exist, and behaviour is otherwise identical.

## Structure
- **Package serial_mod_div_pkg** holds:
  - the state enum typedef (IDLE/SHIFT/DONE);
  - a function computing REM_W from DIVISOR.
- **Sub-module mod_step** (combinational): inputs r, b; outputs r_next, q. Parametrised by DIVISOR and REM_W. Unit-testable on its own.

## Test plan
- Default (WIDTH 8, DIVISOR 3), in_data 8'b10101001 (169) → quo 56, rem 1, divisible 0; out_valid exactly 8 cycles after the accept edge.
- in_data 170 → quo 56, rem 2. Then in_data 255 → quo 85, rem 0, divisible 1. Both issued back-to-back with out_ready tied high; the second is accepted in the DONE cycle of the first.
- DIVISOR 7, WIDTH 8, in_data 100 → quo 14, rem 2. Also in_data 0 → quo 0, rem 0, divisible 1.
- Hold out_ready low 5 cycles after out_valid → quo, rem and divisible stable; in_ready low; in_valid pulses meanwhile are ignored.
- Assert rst_n low for one cycle mid-SHIFT (cycle 4 of 8) → immediate reset values, no out_valid. A following operand of 9 gives quo 3, rem 0.
- With SERIAL_MOD_DIV_STREAM_EN, in_data 169 / 3 → q_bit sequence 0,0,1,1,1,0,0,0 over 8 q_bit_valid pulses.
